// File: rtl/fetch_stage_if.sv
// rtl/fetch_stage_if.sv - instruction-memory bus and IF/ID register bundle for the fetch stage
interface fetch_stage_if;
  logic [31:0] inst_addr;
  logic [31:0] instruction;
  logic [31:0] if_id_pc;
  logic [31:0] if_id_instruction;
  logic        if_id_valid;

  modport master (
    output inst_addr,
    input  instruction,
    output if_id_pc,
    output if_id_instruction,
    output if_id_valid
  );

  modport slave (
    input  inst_addr,
    output instruction,
    input  if_id_pc,
    input  if_id_instruction,
    input  if_id_valid
  );
endinterface

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - IF stage: PC register, IF/ID pipeline register, redirect/freeze, perf counters
module fetch_stage #(
  parameter logic [31:0] PC_RESET    = 32'h0000_0000,
  parameter int          FLUSH_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   freeze,
  input  logic                   branch_taken,
  input  logic [31:0]            branch_addr,
  fetch_stage_if.master          bus,
  output logic [31:0]            fetch_count,
  output logic [FLUSH_CNT_W-1:0] flush_count
);

  localparam logic [FLUSH_CNT_W-1:0] FLUSH_ONE = 1;

  // Only the word index is stored, so the fetch address can never be misaligned.
  logic [29:0] pc_word;
  logic [29:0] pc_word_next;
  logic [31:0] pc_plus4;
  logic [31:0] if_id_pc_q;
  logic [31:0] if_id_instruction_q;
  logic        if_id_valid_q;

  assign pc_word_next = pc_word + 30'd1;
  assign pc_plus4     = {pc_word_next, 2'b00};

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_word             <= PC_RESET[31:2];
      if_id_pc_q          <= 32'd0;
      if_id_instruction_q <= 32'd0;
      if_id_valid_q       <= 1'b0;
      fetch_count         <= 32'd0;
      flush_count         <= '0;
    end else if (branch_taken) begin
      // Redirect wins over freeze: the instruction in IF/ID is on the wrong path.
      pc_word             <= branch_addr[31:2];
      if_id_pc_q          <= 32'd0;
      if_id_instruction_q <= 32'd0;
      if_id_valid_q       <= 1'b0;
      flush_count         <= flush_count + FLUSH_ONE;
    end else if (!freeze) begin
      pc_word             <= pc_word_next;
      if_id_pc_q          <= pc_plus4;
      if_id_instruction_q <= bus.instruction;
      if_id_valid_q       <= 1'b1;
      fetch_count         <= fetch_count + 32'd1;
    end
  end

  assign bus.inst_addr         = {pc_word, 2'b00};
  assign bus.if_id_pc          = if_id_pc_q;
  assign bus.if_id_instruction = if_id_instruction_q;
  assign bus.if_id_valid       = if_id_valid_q;

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - self-checking bench for fetch_stage against a behavioural model
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        freeze = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_addr = 32'd0;
  logic [31:0] fetch_count;
  logic [15:0] flush_count;

  fetch_stage_if fif ();

  fetch_stage #(.PC_RESET(32'h0000_0000), .FLUSH_CNT_W(16)) dut (
    .clk          (clk),
    .rst          (rst),
    .freeze       (freeze),
    .branch_taken (branch_taken),
    .branch_addr  (branch_addr),
    .bus          (fif),
    .fetch_count  (fetch_count),
    .flush_count  (flush_count)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0:   return 32'hE3A0_0014;
      32'h4:   return 32'hE3A0_1A01;
      32'h8:   return 32'hE3A0_2103;
      32'hC:   return 32'hE092_3002;
      default: return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
    endcase
  endfunction

  assign fif.instruction = mem_word(fif.inst_addr);

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: architectural state updated from the stage's rules each edge.
  logic [31:0] m_pc, m_ifpc, m_ifins, m_fetch;
  logic        m_valid;
  logic [15:0] m_flush;
  bit          m_ready = 0;

  always @(posedge clk) begin
    if (rst) begin
      m_pc = 32'h0; m_ifpc = 0; m_ifins = 0; m_valid = 0; m_fetch = 0; m_flush = 0;
      m_ready = 1;
    end else if (m_ready) begin
      if (branch_taken) begin
        m_pc = branch_addr & ~32'h3;
        m_ifpc = 0; m_ifins = 0; m_valid = 0;
        m_flush = m_flush + 16'd1;
      end else if (!freeze) begin
        m_ifins = mem_word(m_pc);
        m_pc = m_pc + 32'd4;
        m_ifpc = m_pc;
        m_valid = 1;
        m_fetch = m_fetch + 32'd1;
      end
    end
  end

  always @(negedge clk) begin
    if (m_ready) begin
      check("inst_addr", fif.inst_addr, m_pc);
      check("if_id_pc", fif.if_id_pc, m_ifpc);
      check("if_id_instruction", fif.if_id_instruction, m_ifins);
      check("if_id_valid", {31'd0, fif.if_id_valid}, {31'd0, m_valid});
      check("fetch_count", fetch_count, m_fetch);
      check("flush_count", {16'd0, flush_count}, {16'd0, m_flush});
    end
  end

  task automatic cyc(input logic r, input logic f, input logic b, input logic [31:0] a);
    rst = r; freeze = f; branch_taken = b; branch_addr = a;
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  initial begin
    cyc(1, 0, 0, 0);
    cyc(1, 0, 0, 0);
    check("rst_inst_addr", fif.inst_addr, 32'h0);
    check("rst_valid", {31'd0, fif.if_id_valid}, 32'd0);
    check("rst_fetch", fetch_count, 32'd0);

    cyc(0, 0, 0, 0);
    check("adv1_addr", fif.inst_addr, 32'h4);
    check("adv1_pc", fif.if_id_pc, 32'h4);
    check("adv1_ins", fif.if_id_instruction, 32'hE3A0_0014);
    cyc(0, 0, 0, 0);
    check("adv2_ins", fif.if_id_instruction, 32'hE3A0_1A01);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);
    check("adv4_addr", fif.inst_addr, 32'h10);
    check("adv4_ins", fif.if_id_instruction, 32'hE092_3002);
    check("adv4_fetch", fetch_count, 32'd4);

    for (int i = 0; i < 3; i++) begin
      cyc(0, 1, 0, 0);
      check("frz_addr", fif.inst_addr, 32'h10);
      check("frz_pc", fif.if_id_pc, 32'h10);
    end
    cyc(0, 0, 0, 0);
    check("unfrz_pc", fif.if_id_pc, 32'h14);
    check("unfrz_ins", fif.if_id_instruction, mem_word(32'h10));

    cyc(0, 1, 1, 32'h98);
    check("br_addr", fif.inst_addr, 32'h98);
    check("br_valid", {31'd0, fif.if_id_valid}, 32'd0);
    check("br_ins", fif.if_id_instruction, 32'd0);
    check("br_flush", {16'd0, flush_count}, 32'd1);
    check("br_fetch", fetch_count, 32'd5);
    cyc(0, 0, 0, 0);
    check("br_next_pc", fif.if_id_pc, 32'h9C);

    cyc(0, 0, 1, 32'h73);
    check("misalign_addr", fif.inst_addr, 32'h70);

    cyc(0, 0, 1, 32'hFFFF_FFFC);
    cyc(0, 0, 0, 0);
    check("wrap_pc", fif.if_id_pc, 32'h0);
    check("wrap_addr", fif.inst_addr, 32'h0);

    cyc(1, 1, 1, 32'h44);
    check("rst_br_addr", fif.inst_addr, 32'h0);
    check("rst_br_flush", {16'd0, flush_count}, 32'd0);
    check("rst_br_fetch", fetch_count, 32'd0);

    for (int i = 0; i < 600; i++) begin
      cyc(($urandom_range(0, 49) == 0), ($urandom_range(0, 3) == 0),
          ($urandom_range(0, 5) == 0), $urandom);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch (IF) stage of the 5-stage ARM pipeline; sits directly upstream of the byte-addressed instruction memory and feeds the decode stage.
- Owns the program counter and drives the fetch address to instruction memory. Memory returns the instruction combinationally in the same cycle.
- Captures the fetched word plus PC+4 into the IF/ID pipeline register.
- Handles hazard freeze and branch redirect/flush, and keeps fetch/flush performance counters.

Parameters:
- PC_RESET, 32'h0000_0000, PC value loaded on reset.
- FLUSH_CNT_W, 16, width of the flush counter.

Ports:
- clk  input  1  pipeline clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- freeze  input  1  hazard stall from hazard unit; holds PC and IF/ID.
- branch_taken  input  1  redirect from EXE stage; also flushes IF/ID.
- branch_addr  input  32  byte address of branch target.
- instruction  input  32  word returned by instruction memory for inst_addr.
- inst_addr  output  32  fetch byte address to instruction memory (= current PC).
- if_id_pc  output  32  PC+4 of the instruction held in IF/ID.
- if_id_instruction  output  32  instruction held in IF/ID.
- if_id_valid  output  1  IF/ID holds a real instruction (not a bubble).
- fetch_count  output  32  number of instructions latched into IF/ID.
- flush_count  output  FLUSH_CNT_W  number of branch flushes.

Behaviour:
- Reset values: sampled at posedge when rst=1.
  - PC is set to {PC_RESET[31:2],2'b00}.
  - if_id_pc, if_id_instruction, fetch_count and flush_count are 0; if_id_valid is 0.
  - rst overrides every other input, including mid-stall or mid-branch.
- inst_addr is combinational from the PC register and always word-aligned (PC[1:0] is always 0).
- Per-edge priority when rst=0: branch_taken > freeze > normal advance.
- branch_taken=1, regardless of freeze:
  - PC <= {branch_addr[31:2],2'b00}; misaligned low bits are ignored.
  - IF/ID becomes a bubble: pc=0, instruction=0, valid=0.
  - flush_count increments; fetch_count is unchanged.
- freeze=1 and branch_taken=0: PC, all IF/ID fields and both counters hold.
- Normal advance (neither asserted):
  - PC <= PC+4.
  - if_id_pc <= PC+4; if_id_instruction <= instruction; if_id_valid <= 1.
  - fetch_count increments.
- Latency:
  - An instruction at address A appears on if_id_instruction one edge after inst_addr=A, with if_id_pc=A+4.
  - The branch target is presented on inst_addr the cycle after branch_taken is sampled, and reaches IF/ID one further edge later.
- Arithmetic:
  - PC+4 is 32-bit modulo; 32'hFFFF_FFFC + 4 wraps to 0 with no flag.
  - Both counters wrap modulo 2^width silently.
- The instruction input is sampled only on advancing edges; its value during freeze or branch cycles is don't-care.
- No internal FSM beyond the register set. The stage is always fetching; there is no halt state.

Test Plan:
- Reset then 4 free-running cycles with memory returning E3A00014, E3A01A01, E3A02103, E0923002 at 0/4/8/12:
  - inst_addr sequence is 0,4,8,12,16.
  - IF/ID shows (4,E3A00014), (8,E3A01A01), … with valid=1.
  - fetch_count=4.
- freeze held 3 cycles with PC=0x10:
  - inst_addr stays 0x10 and IF/ID is unchanged for 3 edges.
  - After release, the next edge latches (0x14, word@0x10).
- branch_taken=1, branch_addr=0x0000_0098, freeze=1 in the same cycle:
  - Next cycle inst_addr=0x98, if_id_valid=0, if_id_instruction=0, flush_count=1, fetch_count unchanged.
  - Following edge latches if_id_pc=0x9C.
- branch_addr=0x0000_0073: PC becomes 0x70; inst_addr[1:0]=0.
- rst asserted on the same edge as branch_taken=1 and freeze=1:
  - PC=PC_RESET, all IF/ID fields 0, both counters 0.
- Wrap check: force PC to 0xFFFF_FFFC (branch_addr=0xFFFF_FFFC), then one advance:
  - if_id_pc=0x0000_0000 and inst_addr=0.
